// File: rtl/z_hilo_writeback_pkg.sv
// Shared encodings for the HI/LO writeback stage and the 64-bit mul/div units.
package z_hilo_writeback_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } state_e;

  localparam logic SEL_LO = 1'b0;
  localparam logic SEL_HI = 1'b1;

  // 64-bit result split: LO occupies [LO_MSB:0], HI occupies [63:HI_LSB]
  localparam int LO_MSB = 31;
  localparam int HI_LSB = 32;

endpackage

// File: rtl/z_hilo_writeback_hold_reg.sv
// 64-bit result capture register with load enable and asynchronous active-low clear.
module z_hold_reg (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [63:0] i_data,
  output logic [63:0] o_data
);

  logic [63:0] r_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_data <= '0;
    else if (i_load)
      r_data <= i_data;
  end

  assign o_data = r_data;

endmodule

// File: rtl/z_hilo_writeback.sv
// Splits a captured 64-bit mul/div result into LO then HI beats on the 32-bit bus,
// tracking sticky divide-by-zero status and a count of retired results.
module z_hilo_writeback
  import z_hilo_writeback_pkg::*;
#(
  parameter bit DZ_SUPPRESS = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             res_valid,
  input  logic [63:0]      res_data,
  input  logic             res_is_div,
  input  logic             res_div_zero,
  output logic             res_ready,
  output logic             bus_valid,
  output logic             bus_sel,
  output logic [31:0]      bus_data,
  input  logic             bus_ready,
  output logic             dz_flag,
  input  logic             dz_clr,
  output logic [CNT_W-1:0] done_cnt
);

  state_e            r_state;
  state_e            w_next;
  logic [63:0]       w_hold;
  logic              r_dz;
  logic [CNT_W-1:0]  r_done;
  logic              w_accept;
  logic              w_dz;
  logic              w_suppress;
  logic              w_retire_hi;
  logic              w_retire_dz;

  assign w_accept    = res_valid & res_ready;
  assign w_dz        = res_is_div & res_div_zero;
  assign w_suppress  = DZ_SUPPRESS & w_dz;
  assign w_retire_hi = (r_state == SEND_HI) & bus_ready;
  assign w_retire_dz = w_accept & w_suppress;

  z_hold_reg u_hold (
    .i_clk   (clock),
    .i_rst_n (clear_n),
    .i_load  (w_accept),
    .i_data  (res_data),
    .o_data  (w_hold)
  );

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (res_valid) w_next = w_suppress ? IDLE : SEND_LO;
      SEND_LO: if (bus_ready) w_next = SEND_HI;
      SEND_HI: begin
        if (bus_ready) begin
          if (res_valid) w_next = w_suppress ? IDLE : SEND_LO;
          else           w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Ready looks at bus_ready in SEND_HI so a new result can land on the HI retire edge
  always_comb begin
    res_ready = 1'b0;
    bus_valid = 1'b0;
    bus_sel   = SEL_LO;
    bus_data  = '0;
    case (r_state)
      IDLE:    res_ready = 1'b1;
      SEND_LO: begin
        bus_valid = 1'b1;
        bus_sel   = SEL_LO;
        bus_data  = w_hold[LO_MSB:0];
      end
      SEND_HI: begin
        res_ready = bus_ready;
        bus_valid = 1'b1;
        bus_sel   = SEL_HI;
        bus_data  = w_hold[63:HI_LSB];
      end
      default: ;
    endcase
  end

  // A new divide-by-zero capture outranks a simultaneous clear
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n)
      r_dz <= 1'b0;
    else if (w_accept & w_dz)
      r_dz <= 1'b1;
    else if (dz_clr)
      r_dz <= 1'b0;
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n)
      r_done <= '0;
    else
      r_done <= r_done + CNT_W'(w_retire_hi) + CNT_W'(w_retire_dz);
  end

  assign dz_flag  = r_dz;
  assign done_cnt = r_done;

endmodule

// File: tb/tb_z_hilo_writeback.sv
// Directed bench for z_hilo_writeback: a suppressing instance and a non-suppressing one share stimulus.
module tb_z_hilo_writeback;

  logic        clock = 1'b0;
  logic        clear_n = 1'b1;
  logic        res_valid = 1'b0;
  logic [63:0] res_data = '0;
  logic        res_is_div = 1'b0;
  logic        res_div_zero = 1'b0;
  logic        bus_ready = 1'b1;
  logic        dz_clr = 1'b0;

  logic        res_ready, bus_valid, bus_sel, dz_flag;
  logic [31:0] bus_data;
  logic [15:0] done_cnt;
  logic        res_ready_0, bus_valid_0, bus_sel_0, dz_flag_0;
  logic [31:0] bus_data_0;
  logic [15:0] done_cnt_0;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = '0;

  always #5 clock = ~clock;

  z_hilo_writeback #(.DZ_SUPPRESS(1'b1), .CNT_W(16)) dut (
    .clock(clock), .clear_n(clear_n), .res_valid(res_valid), .res_data(res_data),
    .res_is_div(res_is_div), .res_div_zero(res_div_zero), .res_ready(res_ready),
    .bus_valid(bus_valid), .bus_sel(bus_sel), .bus_data(bus_data), .bus_ready(bus_ready),
    .dz_flag(dz_flag), .dz_clr(dz_clr), .done_cnt(done_cnt)
  );

  z_hilo_writeback #(.DZ_SUPPRESS(1'b0), .CNT_W(16)) dut0 (
    .clock(clock), .clear_n(clear_n), .res_valid(res_valid), .res_data(res_data),
    .res_is_div(res_is_div), .res_div_zero(res_div_zero), .res_ready(res_ready_0),
    .bus_valid(bus_valid_0), .bus_sel(bus_sel_0), .bus_data(bus_data_0), .bus_ready(bus_ready),
    .dz_flag(dz_flag_0), .dz_clr(dz_clr), .done_cnt(done_cnt_0)
  );

  task automatic do_reset();
    #2 clear_n = 1'b0;
    #1;
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", bus_valid); end
    checks++; if (bus_sel !== 1'b0) begin errors++; $display("FAIL rst_sel: got %b exp 0", bus_sel); end
    checks++; if (bus_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h exp 0", bus_data); end
    checks++; if (dz_flag !== 1'b0) begin errors++; $display("FAIL rst_dz: got %b exp 0", dz_flag); end
    checks++; if (done_cnt !== 16'h0) begin errors++; $display("FAIL rst_cnt: got %h exp 0", done_cnt); end
    @(negedge clock);
    clear_n = 1'b1;
    exp_cnt = '0;
    @(negedge clock);
    checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b exp 1", res_ready); end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_divide();
    res_valid = 1'b1; res_data = 64'h00000002_00000003; res_is_div = 1'b1; res_div_zero = 1'b0;
    bus_ready = 1'b1;
    @(negedge clock);
    res_valid = 1'b0;
    checks++; if ({bus_valid, bus_sel, bus_data} !== {2'b10, 32'h00000003})
      begin errors++; $display("FAIL div_lo: got v%b s%b %h exp v1 s0 00000003", bus_valid, bus_sel, bus_data); end
    checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL div_lo_ready: got %b exp 0", res_ready); end
    @(negedge clock);
    checks++; if ({bus_valid, bus_sel, bus_data} !== {2'b11, 32'h00000002})
      begin errors++; $display("FAIL div_hi: got v%b s%b %h exp v1 s1 00000002", bus_valid, bus_sel, bus_data); end
    @(negedge clock);
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL div_idle: got %b exp 0", bus_valid); end
    checks++; if (done_cnt !== exp_cnt) begin errors++; $display("FAIL div_cnt: got %h exp %h", done_cnt, exp_cnt); end
    checks++; if (dz_flag !== 1'b0) begin errors++; $display("FAIL div_dz: got %b exp 0", dz_flag); end
  endtask

  task automatic test_stall();
    // Multiply with res_div_zero set must not touch dz_flag
    res_valid = 1'b1; res_data = 64'hDEADBEEF_01234567; res_is_div = 1'b0; res_div_zero = 1'b1;
    bus_ready = 1'b0;
    @(negedge clock);
    res_valid = 1'b0; res_data = 64'h11111111_22222222; res_is_div = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({bus_valid, bus_sel, bus_data} !== {2'b10, 32'h01234567})
        begin errors++; $display("FAIL stall_lo%0d: got v%b s%b %h exp v1 s0 01234567", i, bus_valid, bus_sel, bus_data); end
      @(negedge clock);
    end
    checks++; if ({bus_valid, bus_sel, bus_data} !== {2'b10, 32'h01234567})
      begin errors++; $display("FAIL stall_lo_last: got v%b s%b %h exp v1 s0 01234567", bus_valid, bus_sel, bus_data); end
    bus_ready = 1'b1;
    @(negedge clock);
    checks++; if ({bus_valid, bus_sel, bus_data} !== {2'b11, 32'hDEADBEEF})
      begin errors++; $display("FAIL stall_hi: got v%b s%b %h exp v1 s1 deadbeef", bus_valid, bus_sel, bus_data); end
    @(negedge clock);
    exp_cnt = exp_cnt + 16'd1;
    res_is_div = 1'b0; res_div_zero = 1'b0;
    checks++; if (done_cnt !== exp_cnt) begin errors++; $display("FAIL stall_cnt: got %h exp %h", done_cnt, exp_cnt); end
    checks++; if (dz_flag !== 1'b0) begin errors++; $display("FAIL mul_dz_ignored: got %b exp 0", dz_flag); end
  endtask

  task automatic test_div_zero();
    res_valid = 1'b1; res_data = 64'hFFFFFFFF_FFFFFFFF; res_is_div = 1'b1; res_div_zero = 1'b1;
    bus_ready = 1'b1;
    @(negedge clock);
    res_valid = 1'b0; res_div_zero = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL dz_sup_valid: got %b exp 0", bus_valid); end
    checks++; if (dz_flag !== 1'b1) begin errors++; $display("FAIL dz_sup_flag: got %b exp 1", dz_flag); end
    checks++; if (done_cnt !== exp_cnt) begin errors++; $display("FAIL dz_sup_cnt: got %h exp %h", done_cnt, exp_cnt); end
    checks++; if ({bus_valid_0, bus_sel_0, bus_data_0} !== {2'b10, 32'hFFFFFFFF})
      begin errors++; $display("FAIL dz_nosup_lo: got v%b s%b %h exp v1 s0 ffffffff", bus_valid_0, bus_sel_0, bus_data_0); end
    checks++; if (dz_flag_0 !== 1'b1) begin errors++; $display("FAIL dz_nosup_flag: got %b exp 1", dz_flag_0); end
    @(negedge clock);
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL dz_sup_valid2: got %b exp 0", bus_valid); end
    checks++; if ({bus_valid_0, bus_sel_0, bus_data_0} !== {2'b11, 32'hFFFFFFFF})
      begin errors++; $display("FAIL dz_nosup_hi: got v%b s%b %h exp v1 s1 ffffffff", bus_valid_0, bus_sel_0, bus_data_0); end
    dz_clr = 1'b1;
    @(negedge clock);
    dz_clr = 1'b0;
    checks++; if (bus_valid_0 !== 1'b0) begin errors++; $display("FAIL dz_nosup_idle: got %b exp 0", bus_valid_0); end
    checks++; if (dz_flag !== 1'b0) begin errors++; $display("FAIL dz_clr: got %b exp 0", dz_flag); end
    checks++; if (dz_flag_0 !== 1'b0) begin errors++; $display("FAIL dz_clr0: got %b exp 0", dz_flag_0); end
  endtask

  task automatic test_back_to_back();
    res_valid = 1'b1; res_data = 64'hAAAA0001_5555_0001; res_is_div = 1'b0; bus_ready = 1'b1;
    @(negedge clock);
    res_data = 64'hBBBB0002_66660002;
    checks++; if ({bus_valid, bus_sel, bus_data} !== {2'b10, 32'h55550001})
      begin errors++; $display("FAIL b2b_lo1: got v%b s%b %h exp v1 s0 55550001", bus_valid, bus_sel, bus_data); end
    @(negedge clock);
    checks++; if ({bus_valid, bus_sel, bus_data} !== {2'b11, 32'hAAAA0001})
      begin errors++; $display("FAIL b2b_hi1: got v%b s%b %h exp v1 s1 aaaa0001", bus_valid, bus_sel, bus_data); end
    checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b exp 1", res_ready); end
    @(negedge clock);
    res_valid = 1'b0;
    checks++; if ({bus_valid, bus_sel, bus_data} !== {2'b10, 32'h66660002})
      begin errors++; $display("FAIL b2b_lo2: got v%b s%b %h exp v1 s0 66660002", bus_valid, bus_sel, bus_data); end
    @(negedge clock);
    checks++; if ({bus_valid, bus_sel, bus_data} !== {2'b11, 32'hBBBB0002})
      begin errors++; $display("FAIL b2b_hi2: got v%b s%b %h exp v1 s1 bbbb0002", bus_valid, bus_sel, bus_data); end
    @(negedge clock);
    exp_cnt = exp_cnt + 16'd2;
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b exp 0", bus_valid); end
    checks++; if (done_cnt !== exp_cnt) begin errors++; $display("FAIL b2b_cnt: got %h exp %h", done_cnt, exp_cnt); end
  endtask

  task automatic test_clear_mid();
    res_valid = 1'b1; res_data = 64'hFFFFFFFF_FFFFFFFF; res_is_div = 1'b1; res_div_zero = 1'b1;
    @(negedge clock);
    res_valid = 1'b0; res_div_zero = 1'b0; res_is_div = 1'b0;
    repeat (2) @(negedge clock);
    res_valid = 1'b1; res_data = 64'h12345678_9ABCDEF0;
    @(negedge clock);
    res_valid = 1'b0;
    @(negedge clock);
    checks++; if ({bus_valid, bus_sel} !== 2'b11) begin errors++; $display("FAIL clr_pre_hi: got v%b s%b exp v1 s1", bus_valid, bus_sel); end
    clear_n = 1'b0;
    #1;
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL clr_valid: got %b exp 0", bus_valid); end
    checks++; if (dz_flag !== 1'b0) begin errors++; $display("FAIL clr_dz: got %b exp 0", dz_flag); end
    checks++; if (done_cnt !== 16'h0) begin errors++; $display("FAIL clr_cnt: got %h exp 0", done_cnt); end
    @(negedge clock);
    clear_n = 1'b1;
    exp_cnt = '0;
    checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL clr_ready: got %b exp 1", res_ready); end
    res_valid = 1'b1; res_data = 64'hCAFEF00D_0BADC0DE;
    @(negedge clock);
    res_valid = 1'b0;
    checks++; if ({bus_valid, bus_sel, bus_data} !== {2'b10, 32'h0BADC0DE})
      begin errors++; $display("FAIL clr_new_lo: got v%b s%b %h exp v1 s0 0badc0de", bus_valid, bus_sel, bus_data); end
    @(negedge clock);
    checks++; if ({bus_valid, bus_sel, bus_data} !== {2'b11, 32'hCAFEF00D})
      begin errors++; $display("FAIL clr_new_hi: got v%b s%b %h exp v1 s1 cafef00d", bus_valid, bus_sel, bus_data); end
    @(negedge clock);
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (done_cnt !== exp_cnt) begin errors++; $display("FAIL clr_new_cnt: got %h exp %h", done_cnt, exp_cnt); end
  endtask

  task automatic test_wrap();
    int n;
    n = 65535 - int'(exp_cnt);
    res_valid = 1'b1; res_data = 64'hFFFFFFFF_FFFFFFFF; res_is_div = 1'b1; res_div_zero = 1'b1;
    for (int i = 0; i < n; i++) @(negedge clock);
    checks++; if (done_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_max: got %h exp ffff", done_cnt); end
    dz_clr = 1'b1;
    @(negedge clock);
    checks++; if (done_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h exp 0000", done_cnt); end
    checks++; if (dz_flag !== 1'b1) begin errors++; $display("FAIL dz_set_wins: got %b exp 1", dz_flag); end
    res_valid = 1'b0; res_div_zero = 1'b0;
    @(negedge clock);
    dz_clr = 1'b0;
    checks++; if (dz_flag !== 1'b0) begin errors++; $display("FAIL dz_clr_alone: got %b exp 0", dz_flag); end
  endtask

  initial begin
    test_reset();
    test_divide();
    test_stall();
    test_div_zero();
    test_back_to_back();
    test_clear_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
